fwd_pass: RTL

Forward-raster pass of the distance-transform engine. It starts once the initialisation stage has filled the result RAM with 0/1 pixels. It scans the 128×128 image in raster order. For every object pixel it writes min(NW, N, NE, W) + 1 back into the result RAM in place. The backward pass consumes its output.

---
 rtl/dt_pkg.sv | 24 ++
 rtl/dt_min4.sv | 21 ++
 rtl/fwd_pass.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dt_pkg.sv
// dt_pkg: shared constants, FSM states and address helper for the distance-transform passes
package dt_pkg;
    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_NW,
        S_LD_N,
        S_LD_W,
        S_LD_NE,
        S_LD_C,
        S_EVAL,
        S_WR,
        S_NEXT,
        S_DONE
    } dt_state_e;

    // Compose a result-RAM address as {row, col}; col_w is the column field width.
    function automatic logic [31:0] dt_addr(input logic [31:0] row, input logic [31:0] col, input int col_w);
        return (row << col_w) | col;
    endfunction
endpackage

// File: rtl/dt_min4.sv
// dt_min4: minimum of four unsigned pixels, optionally incremented with saturation
module dt_min4 #(
    parameter int PIX_W = 8,
    parameter bit INC   = 1'b1
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] c_i,
    input  logic [PIX_W-1:0] d_i,
    output logic [PIX_W-1:0] m_o
);
    logic [PIX_W-1:0] m_ab, m_cd, m;

    // Pairwise minimum tree, then +1 unless already at full scale
    always_comb begin
        m_ab = (a_i < b_i) ? a_i : b_i;
        m_cd = (c_i < d_i) ? c_i : d_i;
        m    = (m_ab < m_cd) ? m_ab : m_cd;
        m_o  = (INC && (m != '1)) ? m + PIX_W'(1) : m;
    end
endmodule

// File: rtl/fwd_pass.sv
// fwd_pass: forward raster pass of the distance transform, rewriting object pixels in place
module fwd_pass #(
    parameter int IMG_W  = dt_pkg::IMG_W,
    parameter int ADDR_W = dt_pkg::ADDR_W,
    parameter int PIX_W  = dt_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              for_en,
    output logic              for_done,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_rd,
    input  logic [PIX_W-1:0]  res_di,
    output logic              res_wr,
    output logic [PIX_W-1:0]  res_do
);
    import dt_pkg::*;

    localparam int            CW    = ADDR_W / 2;
    localparam logic [CW-1:0] FIRST = CW'(1);
    localparam logic [CW-1:0] LAST  = CW'(IMG_W - 2);

    dt_state_e        state_q, state_d;
    logic [CW-1:0]    r_q, r_d, c_q, c_d;
    logic [PIX_W-1:0] nw_q, nw_d, n_q, n_d, ne_q, ne_d, w_q, w_d, cen_q, cen_d;
    logic             from_w_q, from_w_d;
    logic [PIX_W-1:0] m_val;
    logic [CW-1:0]    a_row, a_col;

    dt_min4 #(.PIX_W(PIX_W), .INC(1'b1)) u_min4 (
        .a_i(nw_q),
        .b_i(n_q),
        .c_i(ne_q),
        .d_i(w_q),
        .m_o(m_val)
    );

    // State, scan position and neighbourhood window registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            r_q      <= FIRST;
            c_q      <= FIRST;
            nw_q     <= '0;
            n_q      <= '0;
            ne_q     <= '0;
            w_q      <= '0;
            cen_q    <= '0;
            from_w_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            nw_q     <= nw_d;
            n_q      <= n_d;
            ne_q     <= ne_d;
            w_q      <= w_d;
            cen_q    <= cen_d;
            from_w_q <= from_w_d;
        end
    end

    // Scan sequencing: each load state captures the data returned for the previous state's read
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        nw_d     = nw_q;
        n_d      = n_q;
        ne_d     = ne_q;
        w_d      = w_q;
        cen_d    = cen_q;
        from_w_d = (state_q == S_LD_W);
        case (state_q)
            S_IDLE: begin
                if (for_en) begin
                    state_d = S_LD_NW;
                    r_d     = FIRST;
                    c_d     = FIRST;
                end
            end
            S_LD_NW: state_d = S_LD_N;
            S_LD_N: begin
                nw_d    = res_di;
                state_d = S_LD_W;
            end
            S_LD_W: begin
                n_d     = res_di;
                state_d = S_LD_NE;
            end
            S_LD_NE: begin
                w_d     = from_w_q ? res_di : w_q;
                state_d = S_LD_C;
            end
            S_LD_C: begin
                ne_d    = res_di;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                cen_d   = res_di;
                state_d = (res_di != '0) ? S_WR : S_NEXT;
            end
            S_WR: state_d = S_NEXT;
            S_NEXT: begin
                nw_d = n_q;
                n_d  = ne_q;
                w_d  = (cen_q == '0) ? '0 : m_val;
                if (c_q == LAST) begin
                    c_d     = FIRST;
                    r_d     = r_q + CW'(1);
                    state_d = (r_q == LAST) ? S_DONE : S_LD_NW;
                end else begin
                    c_d     = c_q + CW'(1);
                    state_d = S_LD_NE;
                end
            end
            S_DONE: state_d = for_en ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: strobes and the window address selected by the current load/write state
    always_comb begin
        res_rd   = state_q inside {S_LD_NW, S_LD_N, S_LD_W, S_LD_NE, S_LD_C};
        res_wr   = (state_q == S_WR);
        for_done = (state_q == S_DONE);
        a_row    = (state_q inside {S_LD_NW, S_LD_N, S_LD_NE}) ? r_q - CW'(1) : r_q;
        a_col    = (state_q inside {S_LD_NW, S_LD_W}) ? c_q - CW'(1) :
                   (state_q == S_LD_NE) ? c_q + CW'(1) : c_q;
        res_addr = (res_rd || res_wr) ? ADDR_W'(dt_addr(32'(a_row), 32'(a_col), CW)) : '0;
        res_do   = res_wr ? m_val : '0;
    end
endmodule
